// File: rtl/systolic_mode_arbiter.sv
// Mode arbiter/sequencer for the shared systolic array: picks conv or transconv, flushes on a
// mode change, grants until done, then holds mode through drain. Optional watchdog: ARB_TIMEOUT_EN.
module systolic_mode_arbiter #(
    parameter int SWITCH_CYCLES  = 4,
    parameter int DRAIN_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CW             = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_conv,
    input  logic req_transconv,
    input  logic done_count,
    output logic mode,
    output logic gnt_conv,
    output logic gnt_transconv,
    output logic flush,
    output logic drain,
    output logic busy,
    output logic timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWITCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam logic [CW-1:0] SWITCH_LOAD = CW'(SWITCH_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LOAD  = CW'(DRAIN_CYCLES - 1);

    generate
        if (SWITCH_CYCLES < 1 || DRAIN_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
            SWITCH_CYCLES > 2**CW || DRAIN_CYCLES > 2**CW || TIMEOUT_CYCLES > 2**CW) begin : g_param_check
            $error("systolic_mode_arbiter: cycle parameters must be >= 1 and fit in CW bits");
        end
    endgenerate

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic          last_served_q, last_served_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt_conv_q, gnt_conv_d;
    logic          gnt_transconv_q, gnt_transconv_d;
    logic          flush_q, flush_d;
    logic          drain_q, drain_d;
    logic          busy_q, busy_d;
    logic          timeout_d;

    logic          winner;
    logic          granted_req;
    logic          expire;

    // Round-robin tie-break: the requester not served last time wins.
    always_comb begin
        winner = req_transconv;
        if (req_conv && req_transconv) begin
            winner = ~last_served_q;
        end
    end

    // Owner of the array is always identified by the current mode.
    assign granted_req = mode_q ? req_transconv : req_conv;

`ifdef ARB_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    assign expire = (state_q == ST_RUN) && (cnt_q == TIMEOUT_LAST) && !done_count;
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        last_served_d = last_served_q;
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_conv || req_transconv) begin
                    mode_d = winner;
                    if (winner == mode_q) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_SWITCH;
                        cnt_d   = SWITCH_LOAD;
                    end
                end
            end

            ST_SWITCH: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_RUN: begin
                // A dropped request is an abort, handled exactly like a completion.
                if (done_count || !granted_req || expire) begin
                    state_d       = ST_DRAIN;
                    cnt_d         = DRAIN_LOAD;
                    last_served_d = mode_q;
                    timeout_d     = expire;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`else
                    cnt_d = cnt_q;
`endif
                end
            end

            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        gnt_conv_d      = (state_d == ST_RUN) && !mode_d;
        gnt_transconv_d = (state_d == ST_RUN) && mode_d;
        flush_d         = (state_d == ST_SWITCH);
        drain_d         = (state_d == ST_DRAIN);
        busy_d          = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            mode_q          <= 1'b0;
            last_served_q   <= 1'b1;
            cnt_q           <= '0;
            gnt_conv_q      <= 1'b0;
            gnt_transconv_q <= 1'b0;
            flush_q         <= 1'b0;
            drain_q         <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            mode_q          <= mode_d;
            last_served_q   <= last_served_d;
            cnt_q           <= cnt_d;
            gnt_conv_q      <= gnt_conv_d;
            gnt_transconv_q <= gnt_transconv_d;
            flush_q         <= flush_d;
            drain_q         <= drain_d;
            busy_q          <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic timeout_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = timeout_d;
    assign timeout_err    = 1'b0;
`endif

    assign mode          = mode_q;
    assign gnt_conv      = gnt_conv_q;
    assign gnt_transconv = gnt_transconv_q;
    assign flush         = flush_q;
    assign drain         = drain_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_systolic_mode_arbiter.sv
// Directed bench for systolic_mode_arbiter: grant latency, flush/drain lengths, round-robin,
// abort, reset mid-sequence and (with ARB_TIMEOUT_EN) the watchdog.
module tb_systolic_mode_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req_conv = 1'b0;
    logic req_transconv = 1'b0;
    logic done_count = 1'b0;
    logic mode, gnt_conv, gnt_transconv, flush, drain, busy, timeout_err;

    int vectors = 0;
    int fails   = 0;
    int overlap = 0;
    int to_seen = 0;

    always #5 clk = ~clk;

    systolic_mode_arbiter #(
        .SWITCH_CYCLES (4),
        .DRAIN_CYCLES  (16),
        .TIMEOUT_CYCLES(32),
        .CW            (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_conv     (req_conv),
        .req_transconv(req_transconv),
        .done_count   (done_count),
        .mode         (mode),
        .gnt_conv     (gnt_conv),
        .gnt_transconv(gnt_transconv),
        .flush        (flush),
        .drain        (drain),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1ns later, and track invariants on every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (gnt_conv && gnt_transconv) overlap++;
        if ((gnt_conv || gnt_transconv) && flush) overlap++;
        if (timeout_err) to_seen++;
    endtask

    task automatic wait_drain_end(input string tag);
        int nd;
        nd = 0;
        while (drain && nd < 64) begin
            nd++;
            tick();
        end
        chk({tag, "_drain_len"}, nd, 16);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    // One job from IDLE: arbitrate, wait for grant, run, finish (done or abort), drain.
    task automatic do_job(input string tag, input logic exp_mode, input int exp_wait,
                          input int run_len, input bit abort, input bit release_req);
        int n, nf;
        tick();
        chk({tag, "_mode_arb"}, mode, exp_mode);
        n  = 0;
        nf = 0;
        while (!(gnt_conv || gnt_transconv) && n < 64) begin
            if (flush) nf++;
            tick();
            n++;
        end
        $display("job %s: mode=%0d grant_wait=%0d flush_cycles=%0d", tag, mode, n, nf);
        chk({tag, "_gnt_wait"}, n, exp_wait);
        chk({tag, "_flush_cnt"}, nf, exp_wait);
        chk({tag, "_gnt_conv"}, gnt_conv, !exp_mode);
        chk({tag, "_gnt_tconv"}, gnt_transconv, exp_mode);
        chk({tag, "_busy_run"}, busy, 1);
        for (int i = 1; i < run_len; i++) tick();
        if (abort) begin
            if (exp_mode) req_transconv = 1'b0;
            else req_conv = 1'b0;
        end else begin
            done_count = 1'b1;
        end
        tick();
        done_count = 1'b0;
        if (release_req) begin
            req_conv      = 1'b0;
            req_transconv = 1'b0;
        end
        chk({tag, "_drain_on"}, drain, 1);
        chk({tag, "_gnt_off"}, {gnt_conv, gnt_transconv}, 0);
        wait_drain_end(tag);
        chk({tag, "_mode_hold"}, mode, exp_mode);
    endtask

    initial begin
        int n;

        // Reset state
        tick();
        tick();
        chk("rst_outs", {mode, gnt_conv, gnt_transconv, flush, drain, busy, timeout_err}, 0);
        rst = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // Same-mode conv job, one-cycle grant
        to_seen = 0;
        req_conv = 1'b1;
        do_job("conv1", 1'b0, 0, 5, 1'b0, 1'b1);

        // Mode switch to transconv
        req_transconv = 1'b1;
        do_job("tconv1", 1'b1, 4, 3, 1'b0, 1'b1);

        // Both held across three jobs: conv, transconv, conv
        req_conv      = 1'b1;
        req_transconv = 1'b1;
        do_job("rr1", 1'b0, 4, 3, 1'b0, 1'b0);
        do_job("rr2", 1'b1, 4, 3, 1'b0, 1'b0);
        do_job("rr3", 1'b0, 4, 3, 1'b0, 1'b1);
        chk("no_overlap", overlap, 0);

        // Abort by dropping the request on RUN cycle 10
        req_conv = 1'b1;
        do_job("abort", 1'b0, 0, 10, 1'b1, 1'b1);
        chk("abort_no_to", to_seen, 0);

        // done_count in IDLE is ignored
        done_count = 1'b1;
        tick();
        done_count = 1'b0;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_drain", drain, 0);

`ifdef ARB_TIMEOUT_EN
        to_seen  = 0;
        req_conv = 1'b1;
        tick();
        chk("to_gnt", gnt_conv, 1);
        n = 0;
        while (!timeout_err && n < 100) begin
            tick();
            n++;
        end
        $display("watchdog: timeout_err after %0d cycles in RUN", n);
        chk("to_delay", n, 32);
        chk("to_drain", drain, 1);
        chk("to_gnt_off", gnt_conv, 0);
        req_conv = 1'b0;
        tick();
        chk("to_pulse_len", timeout_err, 0);
        wait_drain_end("to");
        chk("to_single", to_seen, 1);

        to_seen  = 0;
        req_conv = 1'b1;
        tick();
        chk("todone_gnt", gnt_conv, 1);
        for (int i = 0; i < 31; i++) tick();
        done_count = 1'b1;
        tick();
        done_count = 1'b0;
        req_conv   = 1'b0;
        chk("todone_drain", drain, 1);
        chk("todone_no_err", timeout_err, 0);
        wait_drain_end("todone");
        chk("todone_none", to_seen, 0);
`else
        to_seen  = 0;
        req_conv = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) tick();
        $display("no watchdog: gnt_conv=%0d after 41 RUN cycles", gnt_conv);
        chk("nowd_gnt_held", gnt_conv, 1);
        chk("nowd_no_err", to_seen, 0);
        done_count = 1'b1;
        tick();
        done_count = 1'b0;
        req_conv   = 1'b0;
        wait_drain_end("nowd");
`endif

        // Reset during SWITCH
        req_transconv = 1'b1;
        tick();
        chk("sw_flush", flush, 1);
        chk("sw_mode", mode, 1);
        tick();
        rst = 1'b0;
        tick();
        $display("reset mid-SWITCH: mode=%0d flush=%0d busy=%0d", mode, flush, busy);
        chk("rst_sw_outs", {mode, gnt_conv, gnt_transconv, flush, drain, busy, timeout_err}, 0);
        rst           = 1'b1;
        req_transconv = 1'b0;
        tick();
        chk("rst_sw_idle", busy, 0);

        // Reset during DRAIN, then conv granted in one cycle
        req_conv = 1'b1;
        tick();
        chk("dr_gnt", gnt_conv, 1);
        done_count = 1'b1;
        tick();
        done_count = 1'b0;
        chk("dr_drain", drain, 1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        $display("reset mid-DRAIN: drain=%0d busy=%0d", drain, busy);
        chk("rst_dr_outs", {mode, gnt_conv, gnt_transconv, flush, drain, busy, timeout_err}, 0);
        rst = 1'b1;
        tick();
        chk("post_rst_gnt", gnt_conv, 1);
        chk("post_rst_flush", flush, 0);
        done_count = 1'b1;
        tick();
        done_count = 1'b0;
        req_conv   = 1'b0;
        wait_drain_end("post_rst");
        chk("final_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
